// File: rtl/mdu_pkg.sv
// mdu_pkg: shared state encoding and sizing for the iterative divider.
package mdu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DZERO, DONE} state_t;
  localparam int DIV_ITER = 32;
  localparam int CNT_W = $clog2(DIV_ITER);
endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring iteration on the {rem,quo} shift register.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rq,
  input  logic [WIDTH-1:0]   d,
  output logic [2*WIDTH-1:0] rq_n
);
  logic [WIDTH:0] diff;
  // the shifted remainder needs WIDTH+1 bits when the divisor has its MSB set
  always_comb begin
    diff = rq[2*WIDTH-1:WIDTH-1] - {1'b0, d};
    rq_n = diff[WIDTH] ? {rq[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], rq[WIDTH-2:0], 1'b1};
  end
endmodule

// File: rtl/mdu_div_seq.sv
// mdu_div_seq: sequential DIV/DIVU for HI/LO; DIV_ZERO_FAST_EN enables a two-cycle divide-by-zero path.
module mdu_div_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] rq_q, rq_d, rq_step;
  logic [WIDTH-1:0] div_q, div_d, quotient_q, quotient_d, remainder_q, remainder_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, ready_q, ready_d;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign mag_a = (signed_div & a[WIDTH-1]) ? -a : a;
  assign mag_b = (signed_div & b[WIDTH-1]) ? -b : b;
  div_step #(.WIDTH(WIDTH)) u_step (.rq(rq_q), .d(div_q), .rq_n(rq_step));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rq_d = rq_q;
    div_d = div_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    quotient_d = quotient_q;
    remainder_d = remainder_q;
    ready_d = 1'b0;
    if (annul) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          div_d = mag_b;
          qneg_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d = signed_div & a[WIDTH-1];
          cnt_d = '0;
`ifdef DIV_ZERO_FAST_EN
          state_d = (b == '0) ? DZERO : RUN;
          rq_d = {{WIDTH{1'b0}}, (b == '0) ? a : mag_a};
`else
          state_d = RUN;
          rq_d = {{WIDTH{1'b0}}, mag_a};
`endif
        end
        RUN: begin
          rq_d = rq_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
            ready_d = 1'b1;
            quotient_d = qneg_q ? -rq_step[WIDTH-1:0] : rq_step[WIDTH-1:0];
            remainder_d = rneg_q ? -rq_step[2*WIDTH-1:WIDTH] : rq_step[2*WIDTH-1:WIDTH];
          end
        end
        DZERO: begin
          state_d = DONE;
          ready_d = 1'b1;
          quotient_d = '1;
          remainder_d = rq_q[WIDTH-1:0];
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rq_q <= '0;
      div_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      quotient_q <= '0;
      remainder_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rq_q <= rq_d;
      div_q <= div_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      quotient_q <= quotient_d;
      remainder_q <= remainder_d;
      ready_q <= ready_d;
    end
  end
  assign stall = (state_q == IDLE && start && !annul) || state_q == RUN || state_q == DZERO;
  assign ready = ready_q;
  assign quotient = quotient_q;
  assign remainder = remainder_q;
endmodule

// File: tb/tb_mdu_div_seq.sv
// tb_mdu_div_seq: directed scoreboard bench for mdu_div_seq (honours DIV_ZERO_FAST_EN).
module tb_mdu_div_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, signed_div = 1'b0, annul = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic stall, ready;
  logic [31:0] quotient, remainder;
  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int cyc;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 33;
`endif
  mdu_div_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
    .a(a), .b(b), .stall(stall), .ready(ready), .quotient(quotient), .remainder(remainder)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ready: got ready at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("ready_cycle", 32'(cyc), 32'(e.cyc));
        chk("stall_done", {31'b0, stall}, 32'd0);
      end
    end
  end
  task automatic issue(input logic [31:0] ai, input logic [31:0] bi, input logic s,
                       input bit push, input logic [31:0] eq, input logic [31:0] er, input int lat);
    exp_t e;
    @(negedge clk);
    a = ai;
    b = bi;
    signed_div = s;
    start = 1'b1;
    #1 chk("stall_c0", {31'b0, stall}, 32'd1);
    if (push) begin
      e.q = eq;
      e.r = er;
      e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (sb.size() > 0 && n < 60) begin
      @(negedge clk);
      #2 n++;
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    rst = 1'b0;
    issue(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2, 33);
    repeat (31) @(negedge clk);
    #1 chk("stall_c32", {31'b0, stall}, 32'd1);
    wait_done();
    issue(32'hFFFFFFF9, 32'h2, 1'b1, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    wait_done();
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h80000000, 32'h0, 33);
    wait_done();
    issue(32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0, 33);
    wait_done();
    issue(32'd50, 32'd3, 1'b0, 1'b0, '0, '0, 0);
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    #1;
    chk("annul_stall", {31'b0, stall}, 32'd0);
    chk("annul_ready", {31'b0, ready}, 32'd0);
    chk("annul_q_hold", quotient, 32'hFFFFFFFF);
    issue(32'd9, 32'd4, 1'b0, 1'b1, 32'd2, 32'd1, 33);
    wait_done();
    issue(32'd50, 32'd3, 1'b0, 1'b0, '0, '0, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_stall", {31'b0, stall}, 32'd0);
    chk("rst_mid_quotient", quotient, 32'd0);
    chk("rst_mid_remainder", remainder, 32'd0);
    issue(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2, 33);
    repeat (4) @(negedge clk);
    a = 32'd9;
    b = 32'd4;
    signed_div = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    issue(32'd5, 32'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd5, ZLAT);
    wait_done();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
